// File: rtl/demux_sequencer_if.sv
// ----------------------------------------------------------------------------
// demux_sequencer_if
// Bundles the producer handshake and the demux-facing outputs of
// demux_sequencer.
//   data_in  [3:0] word offered by the producer
//   in_valid       data_in (and dest) valid this cycle
//   in_ready       sequencer accepts a word this cycle
//   dest     [1:0] destination lane {Sel1,Sel0} (only with DEST_PORT_EN)
//   In       [3:0] registered data word to the 1-to-4 demux
//   Sel0, Sel1     registered lane select, lane = {Sel1,Sel0}
//   Enable         registered one-cycle dispatch strobe
//   count    [7:0] words dispatched since reset, modulo 256
//   busy           FIFO non-empty or sequencer not idle
// Modports: master = producer / observer side, slave = sequencer side.
// Optional feature macro: DEST_PORT_EN.
// ----------------------------------------------------------------------------
interface demux_sequencer_if;
    logic [3:0] data_in;
    logic       in_valid;
    logic       in_ready;
`ifdef DEST_PORT_EN
    logic [1:0] dest;
`endif
    logic [3:0] In;
    logic       Sel0;
    logic       Sel1;
    logic       Enable;
    logic [7:0] count;
    logic       busy;

`ifdef DEST_PORT_EN
    modport master (
        output data_in, in_valid, dest,
        input  in_ready, In, Sel0, Sel1, Enable, count, busy
    );
    modport slave (
        input  data_in, in_valid, dest,
        output in_ready, In, Sel0, Sel1, Enable, count, busy
    );
`else
    modport master (
        output data_in, in_valid,
        input  in_ready, In, Sel0, Sel1, Enable, count, busy
    );
    modport slave (
        input  data_in, in_valid,
        output in_ready, In, Sel0, Sel1, Enable, count, busy
    );
`endif
endinterface

// File: rtl/demux_sequencer.sv
// ----------------------------------------------------------------------------
// demux_sequencer
// Buffers producer words in a 4-entry FIFO and dispatches them one at a time
// to a downstream 1-to-4 demux: each word gives a single one-cycle Enable
// pulse with the word on In and its lane on {Sel1,Sel0}, followed by at least
// one idle cycle (IDLE -> SEND -> GAP -> SEND/IDLE).
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; flushes FIFO and clears all outputs
//   bus    demux_sequencer_if.slave (handshake + demux outputs)
// Optional feature macro: DEST_PORT_EN
//   defined   : each FIFO entry also stores dest, which drives {Sel1,Sel0}
//   undefined : a 2-bit round-robin lane pointer drives {Sel1,Sel0}
// ----------------------------------------------------------------------------
module demux_sequencer (
    input  logic              clk,
    input  logic              reset,
    demux_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int DEPTH = 4;
`ifdef DEST_PORT_EN
    localparam int ENTRY_W = 6;   // {dest, data}
`else
    localparam int ENTRY_W = 4;   // data only
`endif

    state_t             state_q, state_d;
    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] mem_d [DEPTH];
    logic [2:0]         occ_q, occ_d;
    logic [1:0]         wr_ptr_q, wr_ptr_d;
    logic [1:0]         rd_ptr_q, rd_ptr_d;
    logic [3:0]         in_q, in_d;
    logic [1:0]         sel_q, sel_d;
    logic               enable_q, enable_d;
    logic [7:0]         count_q, count_d;
    logic               busy_q, busy_d;
`ifndef DEST_PORT_EN
    logic [1:0]         lane_q, lane_d;
`endif

    logic               in_ready;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] wr_entry;

    // Ready depends only on registered occupancy and reset, never on in_valid.
    assign in_ready = (occ_q < 3'd4) && !reset;
    assign push     = bus.in_valid && in_ready;
    // A pop coincides with every entry into SEND.
    assign pop      = (state_q != SEND) && (occ_q != 3'd0);

`ifdef DEST_PORT_EN
    assign wr_entry = {bus.dest, bus.data_in};
`else
    assign wr_entry = bus.data_in;
`endif

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        in_d     = in_q;
        sel_d    = sel_q;
        count_d  = count_q;
`ifndef DEST_PORT_EN
        lane_d   = lane_q;
`endif

        if (push) begin
            mem_d[wr_ptr_q] = wr_entry;
            wr_ptr_d        = wr_ptr_q + 2'd1;
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
            in_d     = mem_q[rd_ptr_q][3:0];
            count_d  = count_q + 8'd1;
`ifdef DEST_PORT_EN
            sel_d    = mem_q[rd_ptr_q][5:4];
`else
            sel_d    = lane_q;
            lane_d   = lane_q + 2'd1;
`endif
        end

        // Push and pop together leave occupancy unchanged.
        occ_d = occ_q;
        if (push && !pop) begin
            occ_d = occ_q + 3'd1;
        end else if (pop && !push) begin
            occ_d = occ_q - 3'd1;
        end

        state_d = state_q;
        case (state_q)
            IDLE:    state_d = pop ? SEND : IDLE;
            SEND:    state_d = GAP;
            GAP:     state_d = pop ? SEND : IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next-state view so they line up
        // with the state they describe.
        enable_d = (state_d == SEND);
        busy_d   = (occ_d != 3'd0) || (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        // FIFO storage needs no reset: occupancy and pointers guard it.
        mem_q <= mem_d;
        if (reset) begin
            state_q  <= IDLE;
            occ_q    <= 3'd0;
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            in_q     <= 4'd0;
            sel_q    <= 2'd0;
            enable_q <= 1'b0;
            count_q  <= 8'd0;
            busy_q   <= 1'b0;
`ifndef DEST_PORT_EN
            lane_q   <= 2'd0;
`endif
        end else begin
            state_q  <= state_d;
            occ_q    <= occ_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            in_q     <= in_d;
            sel_q    <= sel_d;
            enable_q <= enable_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
`ifndef DEST_PORT_EN
            lane_q   <= lane_d;
`endif
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.In       = in_q;
    assign bus.Sel0     = sel_q[0];
    assign bus.Sel1     = sel_q[1];
    assign bus.Enable   = enable_q;
    assign bus.count    = count_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_demux_sequencer.sv
// ----------------------------------------------------------------------------
// tb_demux_sequencer
// Scoreboard bench for demux_sequencer. Accepted words are queued with their
// expected lane; every Enable pulse pops the queue and compares In, lane and
// count. Directed sequences cover reset, latency, burst, full FIFO, reset
// during SEND, count wrap and (with DEST_PORT_EN) explicit destinations.
// ----------------------------------------------------------------------------
module tb_demux_sequencer;

    typedef struct {
        logic [3:0] d;
        logic [1:0] lane;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    demux_sequencer_if bus();

    demux_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t       sb[$];
    exp_t       mon_e;
    int         en_hist[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    logic [1:0] lane_model = 2'd0;
    logic [7:0] exp_count  = 8'd0;
    logic       prev_en    = 1'b0;
    bit         saw_full   = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Dispatch monitor, sampled on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (bus.Enable === 1'b1) begin
            en_hist.push_back(cyc);
            check("en_gap", 32'(prev_en), 0);
            if (sb.size() == 0) begin
                check("spurious_en", 32'(bus.Enable), 0);
            end else begin
                mon_e = sb.pop_front();
                exp_count = exp_count + 8'd1;
                check("dout", 32'(bus.In), 32'(mon_e.d));
                check("lane", 32'({bus.Sel1, bus.Sel0}), 32'(mon_e.lane));
                check("count", 32'(bus.count), 32'(exp_count));
            end
        end
        prev_en = (bus.Enable === 1'b1);
    end

    task automatic offer(input logic [3:0] d, input logic [1:0] lane);
        int   waited = 0;
        exp_t e;
        bus.in_valid = 1'b1;
        bus.data_in  = d;
        while (bus.in_ready !== 1'b1 && waited < 50) begin
            saw_full = 1'b1;
            @(negedge clk);
            waited++;
        end
        if (waited >= 50) begin
            check("push_timeout", 32'(bus.in_ready), 1);
            bus.in_valid = 1'b0;
        end else begin
            e.d    = d;
            e.lane = lane;
            sb.push_back(e);
            @(posedge clk);
        end
    endtask

    // Round-robin push: lane comes from the bench's own lane counter.
    task automatic push_word(input logic [3:0] d);
        @(negedge clk);
`ifdef DEST_PORT_EN
        bus.dest = lane_model;
`endif
        offer(d, lane_model);
        lane_model = lane_model + 2'd1;
    endtask

`ifdef DEST_PORT_EN
    task automatic push_dest(input logic [3:0] d, input logic [1:0] ds);
        @(negedge clk);
        bus.dest = ds;
        offer(d, ds);
    endtask
`endif

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit done = 1'b0;
        for (int i = 0; i < 600 && !done; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && bus.busy === 1'b0) done = 1'b1;
        end
        check("drain", 32'(done), 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        sb.delete();
        lane_model = 2'd0;
        exp_count  = 8'd0;
        @(negedge clk);
        check("rst_enable", 32'(bus.Enable), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_count", 32'(bus.count), 0);
        check("rst_in", 32'(bus.In), 0);
        check("rst_sel", 32'({bus.Sel1, bus.Sel0}), 0);
        check("rst_ready", 32'(bus.in_ready), 0);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.data_in  = 4'd0;
`ifdef DEST_PORT_EN
        bus.dest     = 2'd0;
`endif
        repeat (2) @(negedge clk);
        do_reset();
        @(negedge clk);
        check("ready_after_rst", 32'(bus.in_ready), 1);

        // Single word: latency, strobe shape, hold and busy release.
        push_word(4'hA);
        idle();
        check("lat_k0_en", 32'(bus.Enable), 0);
        check("lat_k0_busy", 32'(bus.busy), 1);
        @(negedge clk);
        check("lat_k1_en", 32'(bus.Enable), 1);
        check("lat_k1_in", 32'(bus.In), 32'h0A);
        check("lat_k1_sel", 32'({bus.Sel1, bus.Sel0}), 0);
        @(negedge clk);
        check("gap_en", 32'(bus.Enable), 0);
        check("gap_busy", 32'(bus.busy), 1);
        @(negedge clk);
        check("idle_busy", 32'(bus.busy), 0);
        check("idle_count", 32'(bus.count), 1);
        check("idle_hold_in", 32'(bus.In), 32'h0A);
        check("idle_hold_en", 32'(bus.Enable), 0);

        // Back-to-back burst 1..5 with round-robin lanes, one word per 2 cycles.
        do_reset();
        en_hist.delete();
        for (int i = 1; i <= 5; i++) push_word(4'(i));
        idle();
        wait_drain();
        check("burst_pulses", 32'(en_hist.size()), 5);
        if (en_hist.size() == 5) check("burst_span", 32'(en_hist[4] - en_hist[0]), 8);

        // Eight words with in_valid held: FIFO fills, ready drops, order kept.
        saw_full = 1'b0;
        for (int i = 0; i < 8; i++) push_word(4'(4'hF - i));
        idle();
        check("full_seen", 32'(saw_full), 1);
        wait_drain();

        // Reset during SEND with three words buffered.
        for (int i = 0; i < 6; i++) push_word(4'(i + 3));
        do_reset();
        repeat (12) @(negedge clk);
        check("post_rst_count", 32'(bus.count), 0);
        check("post_rst_busy", 32'(bus.busy), 0);

        // Count wrap: 257 dispatches leave count at 1.
        for (int i = 0; i < 257; i++) push_word(4'(i));
        idle();
        wait_drain();
        check("wrap_count", 32'(bus.count), 1);

        // Random data with random gaps.
        for (int i = 0; i < 30; i++) begin
            push_word(4'($urandom_range(0, 15)));
            if ($urandom_range(0, 2) == 0) begin
                idle();
                repeat ($urandom_range(0, 4)) @(negedge clk);
            end
        end
        idle();
        wait_drain();

`ifdef DEST_PORT_EN
        do_reset();
        en_hist.delete();
        push_dest(4'h7, 2'd2);
        push_dest(4'h9, 2'd2);
        idle();
        wait_drain();
        check("dest_pulses", 32'(en_hist.size()), 2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
